// File: rtl/mem_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_rr_arbiter
// Purpose  : Round-robin sequencer sharing one single-port memory among
//            N_REQ requesters, one read/write transaction at a time.
// Revision : 1.0  initial release
// ============================================================================
module mem_rr_arbiter #(
   parameter int N_REQ = 4,
   parameter int AW    = 5,
   parameter int DW    = 8,
   parameter int PW    = $clog2(N_REQ)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [N_REQ-1:0]    req,
   input  logic [N_REQ-1:0]    we,
   input  logic [N_REQ*AW-1:0] addr,
   input  logic [N_REQ*DW-1:0] wdata,
   output logic [N_REQ-1:0]    ack,
   output logic [DW-1:0]       rdata,
   output logic [PW-1:0]       gnt_id,
   output logic                busy,
   output logic                mem_read,
   output logic                mem_write,
   output logic [AW-1:0]       mem_addr,
   output logic [DW-1:0]       mem_data_in,
   input  logic [DW-1:0]       mem_data_out
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_DONE   = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [PW-1:0]    ptr_q, ptr_d;
   logic [N_REQ-1:0] ack_q, ack_d;
   logic [PW-1:0]    gnt_id_q, gnt_id_d;
   logic             busy_q, busy_d;
   logic             mem_read_q, mem_read_d;
   logic             mem_write_q, mem_write_d;
   logic [AW-1:0]    mem_addr_q, mem_addr_d;
   logic [DW-1:0]    mem_data_in_q, mem_data_in_d;

   logic [AW-1:0]    addr_a  [N_REQ];
   logic [DW-1:0]    wdata_a [N_REQ];

   logic             found;
   logic [PW-1:0]    grant;
   logic [PW:0]      slot;

   for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
      assign addr_a[g]  = addr[g*AW +: AW];
      assign wdata_a[g] = wdata[g*DW +: DW];
   end

   // Search upward from ptr with wrap; slot is one bit wider so the
   // modulo works for non-power-of-two N_REQ.
   always_comb begin
      found = 1'b0;
      grant = '0;
      slot  = '0;
      for (int k = 0; k < N_REQ; k++) begin
         slot = {1'b0, ptr_q} + (PW+1)'(k);
         if (slot >= (PW+1)'(N_REQ)) begin
            slot = slot - (PW+1)'(N_REQ);
         end
         if (!found && req[slot[PW-1:0]]) begin
            found = 1'b1;
            grant = slot[PW-1:0];
         end
      end
   end

   always_comb begin
      state_d       = state_q;
      ptr_d         = ptr_q;
      ack_d         = ack_q;
      gnt_id_d      = gnt_id_q;
      busy_d        = busy_q;
      mem_read_d    = mem_read_q;
      mem_write_d   = mem_write_q;
      mem_addr_d    = mem_addr_q;
      mem_data_in_d = mem_data_in_q;

      case (state_q)
         S_IDLE: begin
            if (found) begin
               gnt_id_d      = grant;
               mem_addr_d    = addr_a[grant];
               mem_data_in_d = wdata_a[grant];
               mem_write_d   = we[grant];
               mem_read_d    = ~we[grant];
               busy_d        = 1'b1;
               if (grant == PW'(N_REQ-1)) begin
                  ptr_d = '0;
               end else begin
                  ptr_d = grant + 1'b1;
               end
               state_d = S_ACCESS;
            end
         end
         S_ACCESS: begin
            mem_read_d  = 1'b0;
            mem_write_d = 1'b0;
            ack_d       = N_REQ'(1) << gnt_id_q;
            state_d     = S_DONE;
         end
         S_DONE: begin
            ack_d   = '0;
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: begin
            ack_d       = '0;
            busy_d      = 1'b0;
            mem_read_d  = 1'b0;
            mem_write_d = 1'b0;
            state_d     = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         ptr_q         <= '0;
         ack_q         <= '0;
         gnt_id_q      <= '0;
         busy_q        <= 1'b0;
         mem_read_q    <= 1'b0;
         mem_write_q   <= 1'b0;
         mem_addr_q    <= '0;
         mem_data_in_q <= '0;
      end else begin
         state_q       <= state_d;
         ptr_q         <= ptr_d;
         ack_q         <= ack_d;
         gnt_id_q      <= gnt_id_d;
         busy_q        <= busy_d;
         mem_read_q    <= mem_read_d;
         mem_write_q   <= mem_write_d;
         mem_addr_q    <= mem_addr_d;
         mem_data_in_q <= mem_data_in_d;
      end
   end

   assign ack         = ack_q;
   assign gnt_id      = gnt_id_q;
   assign busy        = busy_q;
   assign mem_read    = mem_read_q;
   assign mem_write   = mem_write_q;
   assign mem_addr    = mem_addr_q;
   assign mem_data_in = mem_data_in_q;
   assign rdata       = mem_data_out;

`ifndef SYNTHESIS
   always_ff @(posedge clk) begin
      if (rst_n) begin
         assert (!(mem_read_q && mem_write_q));
         assert ($onehot0(ack_q));
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_rr_arbiter
// Purpose  : Scoreboard bench for mem_rr_arbiter with a 32x8 memory model.
// Revision : 1.0  initial release
// ============================================================================
module tb_mem_rr_arbiter;

   localparam int N  = 4;
   localparam int AW = 5;
   localparam int DW = 8;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [N-1:0]    req = '0;
   logic [N-1:0]    we = '0;
   logic [N*AW-1:0] addr = '0;
   logic [N*DW-1:0] wdata = '0;
   logic [N-1:0]    ack;
   logic [DW-1:0]   rdata;
   logic [1:0]      gnt_id;
   logic            busy;
   logic            mem_read;
   logic            mem_write;
   logic [AW-1:0]   mem_addr;
   logic [DW-1:0]   mem_data_in;
   logic [DW-1:0]   mem_dout = '0;

   logic [DW-1:0]   mem [32];
   logic [DW-1:0]   snap [32];
   logic            mem_load = 1'b1;

   int tests = 0;
   int fails = 0;

   typedef struct {
      int           id;
      bit           rd;
      logic [7:0]   data;
   } exp_t;
   exp_t sb[$];

   always #5 clk = ~clk;

   mem_rr_arbiter #(.N_REQ(N), .AW(AW), .DW(DW)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
      .ack(ack), .rdata(rdata), .gnt_id(gnt_id), .busy(busy),
      .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
      .mem_data_in(mem_data_in), .mem_data_out(mem_dout)
   );

   // Memory model: word a initialised to a ^ 8'h5A, registered read.
   always @(posedge clk) begin
      if (mem_load) begin
         for (int k = 0; k < 32; k++) mem[k] <= 8'(k) ^ 8'h5A;
      end else begin
         if (mem_write) mem[mem_addr] <= mem_data_in;
         if (mem_read)  mem_dout <= mem[mem_addr];
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic set_rq(input int i, input logic w, input logic [4:0] a, input logic [7:0] d);
      we[i]            = w;
      addr[i*AW +: AW] = a;
      wdata[i*DW +: DW] = d;
   endtask

   task automatic push(input int id, input bit rd, input logic [7:0] d);
      exp_t e;
      e.id = id; e.rd = rd; e.data = d;
      sb.push_back(e);
   endtask

   // Waits for n acks; requesters drop req on their ack unless keep is set.
   task automatic wait_acks(input int n, input bit keep, output int cyc);
      int seen;
      seen = 0;
      cyc  = 0;
      while (seen < n && cyc < 200) begin
         @(negedge clk);
         cyc++;
         if (ack != '0) begin
            seen++;
            if (!keep) req = req & ~ack;
         end
      end
      if (seen < n) begin
         tests++;
         fails++;
         $display("FAIL ack_timeout: got %0d acks expected %0d", seen, n);
      end
   endtask

   // Scoreboard monitor and invariant checks.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n) begin
         chk("strobe_excl", 32'(mem_read & mem_write), 32'd0);
         chk("ack_onehot0", 32'($onehot0(ack)), 32'd1);
      end
      if (ack != '0) begin
         if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_ack: got %0h expected none", ack);
         end else begin
            e = sb.pop_front();
            chk("ack_id", 32'(ack), 32'(4'b0001 << e.id));
            chk("gnt_id", 32'(gnt_id), 32'(e.id));
            if (e.rd) chk("rdata", 32'(rdata), 32'(e.data));
         end
      end
   end

   initial begin
      int c;
      logic [7:0] rd_exp [4];
      rd_exp[0] = 8'h52; rd_exp[1] = 8'h53; rd_exp[2] = 8'h50; rd_exp[3] = 8'h51;
      for (int i = 0; i < N; i++) set_rq(i, 1'b0, 5'(8 + i), 8'h00);

      // Reset held 2 cycles with every requester asking
      req = 4'hF;
      @(negedge clk);
      mem_load = 1'b0;
      @(negedge clk);
      chk("rst_ack", 32'(ack), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_strobes", 32'({mem_read, mem_write}), 32'd0);
      chk("rst_gnt", 32'(gnt_id), 32'd0);
      chk("rst_addr", 32'({mem_addr, mem_data_in}), 32'd0);
      push(0, 1'b1, rd_exp[0]);
      rst_n = 1'b1;
      wait_acks(1, 1'b0, c);
      req = '0;
      chk("first_grant_lat", 32'(c), 32'd2);
      @(negedge clk);

      // Single write then read on requester 0
      set_rq(0, 1'b1, 5'h03, 8'hA5);
      push(0, 1'b0, 8'h00);
      req = 4'b0001;
      @(negedge clk);
      chk("wr_strobe", 32'({mem_write, mem_read}), 32'b10);
      chk("wr_busy", 32'(busy), 32'd1);
      chk("wr_addr", 32'(mem_addr), 32'h03);
      chk("wr_data", 32'(mem_data_in), 32'hA5);
      @(negedge clk);
      chk("wr_ack", 32'(ack), 32'b0001);
      chk("wr_strobe_off", 32'(mem_write), 32'd0);
      req = '0;
      @(negedge clk);
      chk("wr_ack_clear", 32'({ack, busy}), 32'd0);
      set_rq(0, 1'b0, 5'h03, 8'h00);
      push(0, 1'b1, 8'hA5);
      req = 4'b0001;
      wait_acks(1, 1'b0, c);
      chk("rd_lat", 32'(c), 32'd2);
      set_rq(0, 1'b0, 5'h08, 8'h00);
      @(negedge clk);

      // Round-robin with all requesters continuously re-requesting
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int r = 0; r < 2; r++)
         for (int i = 0; i < N; i++) push(i, 1'b1, rd_exp[i]);
      req = 4'hF;
      wait_acks(4, 1'b1, c);
      chk("rr_4acks_cycles", 32'(c), 32'd11);
      wait_acks(4, 1'b1, c);
      chk("rr_next4_cycles", 32'(c), 32'd12);
      req = '0;
      @(negedge clk);

      // Wrap and skip: reach ptr=3, then 0101, then 1000, then all
      push(2, 1'b1, rd_exp[2]);
      req = 4'b0100;
      wait_acks(1, 1'b0, c);
      push(0, 1'b1, rd_exp[0]);
      push(2, 1'b1, rd_exp[2]);
      req = 4'b0101;
      wait_acks(2, 1'b0, c);
      push(3, 1'b1, rd_exp[3]);
      req = 4'b1000;
      wait_acks(1, 1'b0, c);
      for (int i = 0; i < N; i++) push(i, 1'b1, rd_exp[i]);
      req = 4'hF;
      wait_acks(4, 1'b0, c);
      req = '0;
      @(negedge clk);

      // Data latching: inputs change while the write is in ACCESS
      for (int k = 0; k < 32; k++) snap[k] = mem[k];
      set_rq(1, 1'b1, 5'h1F, 8'h3C);
      push(1, 1'b0, 8'h00);
      req = 4'b0010;
      @(negedge clk);
      chk("latch_addr", 32'(mem_addr), 32'h1F);
      set_rq(1, 1'b1, 5'h05, 8'hFF);
      wait_acks(1, 1'b0, c);
      @(negedge clk);
      chk("latch_mem1F", 32'(mem[31]), 32'h3C);
      for (int k = 0; k < 31; k++) chk("latch_other", 32'(mem[k]), 32'(snap[k]));

      // Reset during ACCESS: ptr is 2, grant goes to 0, then reset
      set_rq(0, 1'b0, 5'h03, 8'h00);
      set_rq(1, 1'b0, 5'h1F, 8'h00);
      req = 4'b0011;
      @(negedge clk);
      chk("rstx_access", 32'({mem_read, gnt_id}), 32'({1'b1, 2'd0}));
      rst_n = 1'b0;
      @(negedge clk);
      chk("rstx_ack", 32'(ack), 32'd0);
      chk("rstx_busy", 32'(busy), 32'd0);
      chk("rstx_strobe", 32'({mem_read, mem_write}), 32'd0);
      rst_n = 1'b1;
      push(0, 1'b1, 8'hA5);
      push(1, 1'b1, 8'h3C);
      wait_acks(2, 1'b0, c);
      req = '0;
      repeat (3) @(negedge clk);
      chk("sb_empty", 32'(sb.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
